move_sequencer_2048: RTL and testbench

Owns the 4x4 2048 board register and sequences each move: line-by-line slide/merge, random tile spawn, then win/game-over evaluation.
Sits between the button front end (debounced direction strobes) and the VGA renderer, which consumes board_out.
Also gives the bench, and any future menu logic, a board preload path.

---
 rtl/move_seq_2048_pkg.sv | 41 ++++
 rtl/line_merge_2048.sv | 49 ++++
 rtl/move_sequencer_2048.sv | 266 ++++++++++++++++++++++++++
 tb/tb_move_sequencer_2048.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_seq_2048_pkg.sv
// Shared types, sizes and helpers for the 2048 move sequencer.
`timescale 1ns/1ps
package move_seq_2048_pkg;

  localparam int CELL_W  = 4;
  localparam int N_CELLS = 16;

  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_U = 2'b10,
    DIR_D = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SLIDE,
    ST_SPAWN,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Board index of element pos of the given line, element 0 being the edge
  // the tiles travel toward. Index = row*4 + col.
  function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] line,
                                          input logic [1:0] pos);
    case (d)
      DIR_L:   return {line, pos};
      DIR_R:   return {line, ~pos};
      DIR_U:   return {pos, line};
      default: return {~pos, line};
    endcase
  endfunction

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/line_merge_2048.sv
// Combinational slide/merge of one 4-cell line; element 0 is the edge the
// tiles move toward. Each tile merges at most once; two 15s never merge.
`timescale 1ns/1ps
module line_merge_2048
  import move_seq_2048_pkg::*;
(
  input  logic [3:0][CELL_W-1:0] line_in,
  output logic [3:0][CELL_W-1:0] line_out,
  output logic                   changed,
  output logic [16:0]            score_inc
);

  logic [4:0][CELL_W-1:0] comp;
  logic [2:0]             fill;
  logic [2:0]             wr;
  logic                   skip;

  // Compact nonzero tiles toward element 0, then merge equal pairs from element 0 outward
  always_comb begin
    comp = '0;
    fill = '0;
    for (int i = 0; i < 4; i++) begin
      if (line_in[i] != '0) begin
        comp[fill] = line_in[i];
        fill       = fill + 3'd1;
      end
    end
    line_out  = '0;
    score_inc = '0;
    wr        = '0;
    skip      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1] && comp[i] != 4'hF) begin
          line_out[wr[1:0]] = comp[i] + 4'd1;
          score_inc         = score_inc + (17'd1 << (comp[i] + 4'd1));
          skip              = 1'b1;
        end else begin
          line_out[wr[1:0]] = comp[i];
        end
        wr = wr + 3'd1;
      end
    end
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/move_sequencer_2048.sv
// 2048 board owner and move sequencer: slide/merge line by line, spawn a
// random tile, evaluate win/game-over. Board preload path included.
// Optional build macro MOVE_SEQ_UNDO_EN adds a one-level undo port.
`timescale 1ns/1ps
module move_sequencer_2048
  import move_seq_2048_pkg::*;
#(
  parameter int          SCORE_W   = 24,
  parameter int          WIN_LOG2  = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               dir_valid,
  input  logic [1:0]         dir,
  input  logic               load_valid,
  input  logic [0:63]        load_board,
`ifdef MOVE_SEQ_UNDO_EN
  input  logic               undo,
`endif
  output logic               busy,
  output logic               move_done,
  output logic               moved,
  output logic [0:63]        board_out,
  output logic [SCORE_W-1:0] score,
  output logic               win,
  output logic               game_over
);

  state_t                          state_q, state_d;
  logic [N_CELLS-1:0][CELL_W-1:0]  cells;
  logic [SCORE_W-1:0]              score_q;
  logic                            win_q, go_q, moved_q, busy_q;
  logic [15:0]                     lfsr;
  dir_t                            dir_q;
  logic [1:0]                      line_idx;
  logic [3:0]                      scan_idx, scan_cnt;
  logic                            spawn_more, in_init;

  logic                            do_load, do_move, enter_spawn, spawn_write;
  logic                            cell_empty;
  logic [CELL_W-1:0]               spawn_val;
  logic [3:0][3:0]                 slide_idx;
  logic [3:0][CELL_W-1:0]          line_in, line_out;
  logic                            line_changed;
  logic [16:0]                     line_inc;
  logic                            board_full, has_pair, has_win;

`ifdef MOVE_SEQ_UNDO_EN
  logic                            do_undo;
  logic [N_CELLS-1:0][CELL_W-1:0]  snap_cells;
  logic [SCORE_W-1:0]              snap_score;
  logic                            snap_valid;
`endif

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [16:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(b);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  assign cell_empty = (cells[scan_idx] == '0);
  assign spawn_val  = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;

  // Gather the line addressed by (dir_q, line_idx) for the merge unit
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      slide_idx[p] = cell_idx(dir_q, line_idx, 2'(p));
      line_in[p]   = cells[slide_idx[p]];
    end
  end

  line_merge_2048 u_line_merge (
    .line_in   (line_in),
    .line_out  (line_out),
    .changed   (line_changed),
    .score_inc (line_inc)
  );

  // Board evaluation: full, any equal orthogonal neighbours, winning tile
  always_comb begin
    board_full = 1'b1;
    has_pair   = 1'b0;
    has_win    = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (cells[i] == '0) board_full = 1'b0;
      if (int'(cells[i]) >= WIN_LOG2) has_win = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (cells[r*4+c] == cells[r*4+c+1]) has_pair = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (cells[i] == cells[i+4]) has_pair = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_d     = state_q;
    do_load     = 1'b0;
    do_move     = 1'b0;
    enter_spawn = 1'b0;
    spawn_write = 1'b0;
    move_done   = 1'b0;
`ifdef MOVE_SEQ_UNDO_EN
    do_undo     = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        enter_spawn = 1'b1;
        state_d     = ST_SPAWN;
      end
      ST_IDLE: begin
        if (load_valid) begin
          do_load = 1'b1;
          state_d = ST_CHECK;
        end
`ifdef MOVE_SEQ_UNDO_EN
        else if (undo && snap_valid) begin
          do_undo = 1'b1;
          state_d = ST_CHECK;
        end
`endif
        else if (dir_valid && !go_q) begin
          do_move = 1'b1;
          state_d = ST_SLIDE;
        end
      end
      ST_SLIDE: begin
        if (line_idx == 2'd3) begin
          if (moved_q || line_changed) begin
            enter_spawn = 1'b1;
            state_d     = ST_SPAWN;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_SPAWN: begin
        spawn_write = cell_empty;
        if (cell_empty || scan_cnt == 4'd15) begin
          if (spawn_more) begin
            enter_spawn = 1'b1;
            state_d     = ST_SPAWN;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: state_d = in_init ? ST_IDLE : ST_DONE;
      ST_DONE: begin
        move_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Sequencing registers: LFSR, latched direction, line and scan counters
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lfsr       <= LFSR_SEED;
      dir_q      <= DIR_L;
      line_idx   <= '0;
      scan_idx   <= '0;
      scan_cnt   <= '0;
      spawn_more <= 1'b0;
      in_init    <= 1'b1;
      moved_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      lfsr   <= lfsr_next(lfsr);
      busy_q <= (state_d != ST_IDLE);
      if (do_move) begin
        dir_q    <= dir_t'(dir);
        line_idx <= '0;
        moved_q  <= 1'b0;
      end
      if (state_q == ST_SLIDE) begin
        line_idx <= line_idx + 2'd1;
        moved_q  <= moved_q | line_changed;
      end
      if (do_load) moved_q <= 1'b1;
`ifdef MOVE_SEQ_UNDO_EN
      if (do_undo) moved_q <= 1'b1;
`endif
      if (enter_spawn) begin
        scan_idx   <= lfsr[3:0];
        scan_cnt   <= '0;
        spawn_more <= (state_q == ST_INIT);
      end else if (state_q == ST_SPAWN) begin
        scan_idx <= scan_idx + 4'd1;
        scan_cnt <= scan_cnt + 4'd1;
      end
      if (state_q == ST_CHECK) in_init <= 1'b0;
    end
  end

  // Board, score and sticky status flags
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cells   <= '0;
      score_q <= '0;
      win_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      if (do_load) begin
        for (int i = 0; i < N_CELLS; i++) cells[i] <= load_board[CELL_W*i +: CELL_W];
      end
`ifdef MOVE_SEQ_UNDO_EN
      else if (do_undo) begin
        cells   <= snap_cells;
        score_q <= snap_score;
        go_q    <= 1'b0;
      end
`endif
      else if (state_q == ST_SLIDE) begin
        for (int p = 0; p < 4; p++) cells[slide_idx[p]] <= line_out[p];
        score_q <= sat_add(score_q, line_inc);
      end else if (spawn_write) begin
        cells[scan_idx] <= spawn_val;
      end
      if (state_q == ST_CHECK) begin
        win_q <= win_q | has_win;
        go_q  <= go_q | (board_full & ~has_pair);
      end
    end
  end

`ifdef MOVE_SEQ_UNDO_EN
  // Pre-move image captured on every accepted move
  always_ff @(posedge clk) begin
    if (do_move) begin
      snap_cells <= cells;
      snap_score <= score_q;
    end
  end

  // Snapshot becomes usable only once the move is known to change the board
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                 snap_valid <= 1'b0;
    else if (do_move || do_undo)                snap_valid <= 1'b0;
    else if (state_q == ST_SLIDE && enter_spawn) snap_valid <= 1'b1;
  end
`endif

  for (genvar g = 0; g < N_CELLS; g++) begin : g_board_out
    assign board_out[CELL_W*g +: CELL_W] = cells[g];
  end

  assign busy      = busy_q;
  assign moved     = moved_q;
  assign score     = score_q;
  assign win       = win_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_move_sequencer_2048.sv
// Scoreboard bench for move_sequencer_2048: directed loads/moves push their
// expected completion; a negedge monitor checks each move_done.
`timescale 1ns/1ps
module tb_move_sequencer_2048;

  localparam int SCORE_W = 24;

  logic               clk = 1'b0;
  logic               clr_n = 1'b0;
  logic               dir_valid = 1'b0;
  logic [1:0]         dir = 2'b00;
  logic               load_valid = 1'b0;
  logic [0:63]        load_board = '0;
`ifdef MOVE_SEQ_UNDO_EN
  logic               undo = 1'b0;
`endif
  logic               busy, move_done, moved, win, game_over;
  logic [0:63]        board_out;
  logic [SCORE_W-1:0] score;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string              name;
    logic [0:63]        board;
    logic [SCORE_W-1:0] score;
    logic               moved;
    logic               win;
    logic               go;
    bit                 spawn;
    int                 lat_min;
    int                 lat_max;
    int                 t0;
  } exp_t;

  exp_t sbq[$];

  move_sequencer_2048 #(.SCORE_W(SCORE_W), .WIN_LOG2(11), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .load_valid (load_valid),
    .load_board (load_board),
`ifdef MOVE_SEQ_UNDO_EN
    .undo       (undo),
`endif
    .busy       (busy),
    .move_done  (move_done),
    .moved      (moved),
    .board_out  (board_out),
    .score      (score),
    .win        (win),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [0:63] b, input logic [SCORE_W-1:0] s,
                              input logic mv, input logic w, input logic g, input bit sp,
                              input int lmin, input int lmax);
    exp_t e;
    e.name = nm; e.board = b; e.score = s; e.moved = mv; e.win = w; e.go = g;
    e.spawn = sp; e.lat_min = lmin; e.lat_max = lmax; e.t0 = 0;
    return e;
  endfunction

  task automatic check_entry(input exp_t e);
    int          lat;
    int          newcnt;
    logic [0:63] masked;
    lat = cyc - e.t0;
    checks++;
    if (lat < e.lat_min || lat > e.lat_max) begin
      errors++;
      $display("FAIL %s_latency: actual %0d required %0d..%0d", e.name, lat, e.lat_min, e.lat_max);
    end
    chk({e.name, "_moved"}, moved, e.moved);
    chk({e.name, "_score"}, score, e.score);
    chk({e.name, "_win"}, win, e.win);
    chk({e.name, "_game_over"}, game_over, e.go);
    if (e.spawn) begin
      masked = board_out;
      newcnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (e.board[4*i +: 4] == 4'd0 && board_out[4*i +: 4] != 4'd0) begin
          newcnt++;
          if (board_out[4*i +: 4] <= 4'd2) masked[4*i +: 4] = 4'd0;
        end
      end
      chk({e.name, "_board_except_spawn"}, masked, e.board);
      chk({e.name, "_spawn_count"}, newcnt, 1);
    end else begin
      chk({e.name, "_board"}, board_out, e.board);
    end
  endtask

  // Monitor: every move_done must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (clr_n && move_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_move_done: actual pulse at cycle %0d required none", cyc);
      end else begin
        e = sbq.pop_front();
        check_entry(e);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sbq.size() != 0 || busy) && n < 300);
    if (sbq.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: actual busy=%0b pending=%0d required idle", nm, busy, sbq.size());
    end
  endtask

  task automatic issue_load(input logic [0:63] b, input exp_t e);
    @(posedge clk); #1;
    e.t0 = cyc;
    sbq.push_back(e);
    load_board = b;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic issue_dir(input logic [1:0] d, input int hold, input bit push, input exp_t e);
    @(posedge clk); #1;
    if (push) begin
      e.t0 = cyc;
      sbq.push_back(e);
    end
    dir       = d;
    dir_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    dir_valid = 1'b0;
  endtask

`ifdef MOVE_SEQ_UNDO_EN
  task automatic issue_undo(input bit push, input exp_t e);
    @(posedge clk); #1;
    if (push) begin
      e.t0 = cyc;
      sbq.push_back(e);
    end
    undo = 1'b1;
    @(posedge clk); #1;
    undo = 1'b0;
  endtask
`endif

  task automatic check_init(input string nm);
    int tiles;
    int big;
    tiles = 0;
    big = 0;
    for (int i = 0; i < 16; i++) begin
      if (board_out[4*i +: 4] != 4'd0) tiles++;
      if (board_out[4*i +: 4] > 4'd2) big++;
    end
    chk({nm, "_tiles"}, tiles, 2);
    chk({nm, "_tile_values"}, big, 0);
    chk({nm, "_score"}, score, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_board"}, board_out, 64'h0);
    chk({nm, "_score"}, score, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_move_done"}, move_done, 0);
    chk({nm, "_moved"}, moved, 0);
    chk({nm, "_win"}, win, 0);
    chk({nm, "_game_over"}, game_over, 0);
  endtask

  localparam logic [0:63] B_PAIRS    = 64'h1122_0000_0000_0000;
  localparam logic [0:63] B_PAIRS_L  = 64'h2300_0000_0000_0000;
  localparam logic [0:63] B_QUAD     = 64'h1111_0000_0000_0000;
  localparam logic [0:63] B_QUAD_R   = 64'h0022_0000_0000_0000;
  localparam logic [0:63] B_LIVE     = 64'h1234_1234_1234_1234;
  localparam logic [0:63] B_DEAD     = 64'h1212_2121_1212_2121;
  localparam logic [0:63] B_TENS     = 64'hAA00_0000_0000_0000;
  localparam logic [0:63] B_2048     = 64'hB000_0000_0000_0000;
  localparam logic [0:63] B_PRERST   = 64'h1100_0000_0000_0000;

  initial begin
    exp_t nop;
    nop = mk("nop", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clr_n = 1'b1;
    @(posedge clk); #1;
    wait_idle("init");
    check_init("init");

    issue_load(B_PAIRS, mk("load_pairs", B_PAIRS, 0, 1, 0, 0, 0, 2, 2));
    wait_idle("load_pairs");
    issue_dir(2'b00, 1, 1, mk("move_l_pairs", B_PAIRS_L, 12, 1, 0, 0, 1, 7, 22));
    wait_idle("move_l_pairs");

    issue_load(B_QUAD, mk("load_quad", B_QUAD, 12, 1, 0, 0, 0, 2, 2));
    wait_idle("load_quad");
    issue_dir(2'b01, 1, 1, mk("move_r_quad", B_QUAD_R, 20, 1, 0, 0, 1, 7, 22));
    wait_idle("move_r_quad");

`ifdef MOVE_SEQ_UNDO_EN
    issue_load(B_PAIRS, mk("load_undo", B_PAIRS, 20, 1, 0, 0, 0, 2, 2));
    wait_idle("load_undo");
    issue_dir(2'b00, 1, 1, mk("move_before_undo", B_PAIRS_L, 32, 1, 0, 0, 1, 7, 22));
    wait_idle("move_before_undo");
    issue_undo(1, mk("undo_restore", B_PAIRS, 20, 1, 0, 0, 0, 2, 2));
    wait_idle("undo_restore");
    issue_undo(0, nop);
    repeat (12) @(negedge clk);
    chk("second_undo_board", board_out, B_PAIRS);
    chk("second_undo_score", score, 20);
`endif

    issue_load(B_LIVE, mk("load_live", B_LIVE, 20, 1, 0, 0, 0, 2, 2));
    wait_idle("load_live");
    issue_dir(2'b00, 4, 1, mk("move_unmoved", B_LIVE, 20, 0, 0, 0, 0, 6, 6));
    wait_idle("move_unmoved");
    repeat (12) @(negedge clk);
    chk("busy_drop_board", board_out, B_LIVE);

    issue_load(B_DEAD, mk("load_dead", B_DEAD, 20, 1, 0, 1, 0, 2, 2));
    wait_idle("load_dead");
    issue_dir(2'b00, 1, 0, nop);
    repeat (12) @(negedge clk);
    chk("dead_ignored_board", board_out, B_DEAD);
    chk("dead_game_over", game_over, 1);
    chk("dead_busy", busy, 0);

    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    check_reset_outputs("reset_pulse");
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    wait_idle("init2");
    check_init("init2");

    issue_load(B_TENS, mk("load_tens", B_TENS, 0, 1, 0, 0, 0, 2, 2));
    wait_idle("load_tens");
    issue_dir(2'b00, 1, 1, mk("merge_to_2048", B_2048, 2048, 1, 1, 0, 1, 7, 22));
    wait_idle("merge_to_2048");

    issue_load(B_PRERST, mk("load_pre_reset", B_PRERST, 2048, 1, 1, 0, 0, 2, 2));
    wait_idle("load_pre_reset");
    issue_dir(2'b00, 1, 0, nop);
    @(posedge clk); #1;
    chk("mid_slide_busy", busy, 1);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_slide");
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    wait_idle("init3");
    check_init("init3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
